// File: rtl/uart_pkg.sv
// Shared UART constants: receiver FSM state encoding, oversample default,
// parity selectors and the nominal clock/baud figures the baud generator uses.
package uart_pkg;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int OVERSAMPLE_DFLT = 16;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  localparam int CLK_HZ = 50_000_000;
  localparam int BAUD   = 115_200;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input; both flops preset to 1
// on reset so an idle-high line never looks active while reset releases.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: oversampled start / DATA_BITS data (LSB first) / parity / stop.
// Define UART_RX_OVERRUN_EN to add the overrun output.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling data bits mid-bit
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; result loads on the following clk
module uart_rx_parity #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = uart_pkg::PARITY_EVEN,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err
`ifdef UART_RX_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_q, stop_d;
  logic                 done_q, done_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 rdy_q, perr_q, ferr_q;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    if (rx_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            tick_d  = '0;
            state_d = START;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DATA: begin
          // tick counter wraps to zero on its own at each mid-bit sample
          tick_d = tick_q + TW'(1);
          if (tick_q == TICK_LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = PARITY;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        PARITY: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == TICK_LAST) begin
            par_d   = rx_s;
            state_d = STOP;
          end
        end
        STOP: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == TICK_LAST) begin
            stop_d  = rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  // a completing frame takes priority over a coincident rd
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      rdy_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else if (done_q) begin
      data_q <= shift_q;
      rdy_q  <= 1'b1;
      perr_q <= ((^shift_q) ^ par_q) != PARITY_ODD;
      ferr_q <= ~stop_q;
    end else if (rd) begin
      rdy_q <= 1'b0;
    end
  end

  assign data       = data_q;
  assign rdy        = rdy_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

`ifdef UART_RX_OVERRUN_EN
  logic ovr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_q <= 1'b0;
    end else if (rd) begin
      ovr_q <= 1'b0;
    end else if (done_q && rdy_q) begin
      ovr_q <= 1'b1;
    end
  end

  assign overrun = ovr_q;
`endif
endmodule

// File: tb/tb_uart_rx_parity.sv
// Self-checking bench for uart_rx_parity: even- and odd-parity instances share
// one serial line; expectations come from a frame-level reference model.
module tb_uart_rx_parity;
  localparam int TICK_DIV = 28;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_en;
  logic       rx;
  logic       rd;
  logic [7:0] data_e, data_o;
  logic       rdy_e, rdy_o, pe_e, pe_o, fe_e, fe_o;
`ifdef UART_RX_OVERRUN_EN
  logic       ovr_e, ovr_o;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_tick = 0;
  int rise_lat = 0;
  int div = 0;
  logic rdy_prev = 1'b0;
  bit hold_seen;

  always #10 clk = ~clk;

  always @(negedge clk) begin
    div   = (div == TICK_DIV - 1) ? 0 : div + 1;
    rx_en = (div == 0);
  end

  always @(posedge clk) begin
    cyc++;
    if (rx_en) last_tick = cyc;
  end

  always @(negedge clk) begin
    if (rdy_e && !rdy_prev) rise_lat = cyc - last_tick;
    rdy_prev = rdy_e;
  end

  uart_rx_parity #(.DATA_BITS(8), .PARITY_ODD(1'b0), .OVERSAMPLE(16)) u_even (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .rx         (rx),
    .rd         (rd),
    .data       (data_e),
    .rdy        (rdy_e),
    .parity_err (pe_e),
    .frame_err  (fe_e)
`ifdef UART_RX_OVERRUN_EN
    ,
    .overrun    (ovr_e)
`endif
  );

  uart_rx_parity #(.DATA_BITS(8), .PARITY_ODD(1'b1), .OVERSAMPLE(16)) u_odd (
    .clk        (clk),
    .rst        (rst),
    .rx_en      (rx_en),
    .rx         (rx),
    .rd         (rd),
    .data       (data_o),
    .rdy        (rdy_o),
    .parity_err (pe_o),
    .frame_err  (fe_o)
`ifdef UART_RX_OVERRUN_EN
    ,
    .overrun    (ovr_o)
`endif
  );

  // Reference: the data bits plus parity bit must have an even (or odd) count of ones.
  function automatic logic exp_perr(input logic [7:0] d, input logic p, input logic odd);
    return (((($countones(d) + int'(p)) % 2) == 1) != odd);
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit hold_rd);
    hold_seen = 1'b0;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = p;
    repeat (BIT_CLKS) @(negedge clk);
    rx = s;
    rd = hold_rd;
    for (int i = 0; i < BIT_CLKS; i++) begin
      @(negedge clk);
      if (rd && rdy_e) begin
        rd = 1'b0;
        hold_seen = 1'b1;
      end
    end
    rd = 1'b0;
    rx = 1'b1;
    repeat (4 * TICK_DIV) @(negedge clk);
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({data_e, rdy_e, pe_e, fe_e, data_o, rdy_o, pe_o, fe_o} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h %b%b%b want 00 000", data_e, rdy_e, pe_e, fe_e);
    end
    rst = 1'b0;
    repeat (20 * TICK_DIV) @(negedge clk);
    checks++;
    if (rdy_e !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_rdy got %b want 0", rdy_e);
    end
  endtask

  task automatic test_clean();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({data_e, rdy_e, pe_e, fe_e} !== {8'hA5, 1'b1, exp_perr(8'hA5, 1'b0, 1'b0), 1'b0}) begin
      errors++;
      $display("FAIL clean_frame got %h %b%b%b want a5 100", data_e, rdy_e, pe_e, fe_e);
    end
    checks++;
    if (rise_lat !== 1) begin
      errors++;
      $display("FAIL clean_latency got %0d want 1", rise_lat);
    end
    checks++;
    if ({data_o, pe_o} !== {8'hA5, exp_perr(8'hA5, 1'b0, 1'b1)}) begin
      errors++;
      $display("FAIL clean_odd got %h pe=%b want a5 pe=1", data_o, pe_o);
    end
  endtask

  task automatic test_parity();
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({data_e, rdy_e, pe_e, fe_e} !== {8'h3C, 1'b1, exp_perr(8'h3C, 1'b1, 1'b0), 1'b0}) begin
      errors++;
      $display("FAIL parity_even got %h %b%b%b want 3c 110", data_e, rdy_e, pe_e, fe_e);
    end
    checks++;
    if ({data_o, rdy_o, pe_o, fe_o} !== {8'h3C, 1'b1, exp_perr(8'h3C, 1'b1, 1'b1), 1'b0}) begin
      errors++;
      $display("FAIL parity_odd got %h %b%b%b want 3c 100", data_o, rdy_o, pe_o, fe_o);
    end
  endtask

  task automatic test_frame();
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({data_e, rdy_e, pe_e, fe_e} !== {8'h00, 1'b1, exp_perr(8'h00, 1'b0, 1'b0), 1'b1}) begin
      errors++;
      $display("FAIL frame_err got %h %b%b%b want 00 101", data_e, rdy_e, pe_e, fe_e);
    end
  endtask

  task automatic test_glitch();
    pulse_rd();
    checks++;
    if (rdy_e !== 1'b0) begin
      errors++;
      $display("FAIL glitch_pre_rd got rdy=%b want 0", rdy_e);
    end
    rx = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (24 * TICK_DIV) @(negedge clk);
    checks++;
    if ({data_e, rdy_e} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL glitch_ignored got %h rdy=%b want 00 rdy=0", data_e, rdy_e);
    end
  endtask

  task automatic test_handshake();
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({data_e, rdy_e, pe_e, fe_e, rise_lat} !== {8'h55, 1'b1, 1'b0, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL hs_frame got %h %b%b%b lat=%0d want 55 100 lat=1", data_e, rdy_e, pe_e, fe_e, rise_lat);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rdy_e !== 1'b1) begin
      errors++;
      $display("FAIL hs_hold got rdy=%b want 1", rdy_e);
    end
    @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    checks++;
    if (rdy_e !== 1'b0 || data_e !== 8'h55) begin
      errors++;
      $display("FAIL hs_rd_clear got rdy=%b data=%h want 0 55", rdy_e, data_e);
    end
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    checks++;
    if ({hold_seen, data_e, rdy_e, pe_e, fe_e} !== {1'b1, 8'hFF, 1'b1, exp_perr(8'hFF, 1'b0, 1'b0), 1'b0}) begin
      errors++;
      $display("FAIL hs_load_wins got seen=%b %h %b%b%b want 1 ff 100", hold_seen, data_e, rdy_e, pe_e, fe_e);
    end
  endtask

`ifdef UART_RX_OVERRUN_EN
  task automatic test_overrun();
    pulse_rd();
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({data_e, rdy_e, ovr_e} !== {8'h11, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ovr_first got %h rdy=%b ovr=%b want 11 1 0", data_e, rdy_e, ovr_e);
    end
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({data_e, rdy_e, ovr_e} !== {8'h22, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovr_set got %h rdy=%b ovr=%b want 22 1 1", data_e, rdy_e, ovr_e);
    end
    pulse_rd();
    checks++;
    if ({rdy_e, ovr_e} !== 2'b00) begin
      errors++;
      $display("FAIL ovr_clear got rdy=%b ovr=%b want 0 0", rdy_e, ovr_e);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] d;
    logic       p, s;
    bit         exp_rdy;
    pulse_rd();
    exp_rdy = 1'b0;
    for (int n = 0; n < 4; n++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, 1'b0);
      checks++;
      if ({data_e, rdy_e, pe_e, fe_e} !== {d, 1'b1, exp_perr(d, p, 1'b0), ~s}) begin
        errors++;
        $display("FAIL rand_even[%0d] got %h %b%b%b want %h 1%b%b", n, data_e, rdy_e, pe_e, fe_e, d, exp_perr(d, p, 1'b0), ~s);
      end
      checks++;
      if ({data_o, pe_o, fe_o} !== {d, exp_perr(d, p, 1'b1), ~s}) begin
        errors++;
        $display("FAIL rand_odd[%0d] got %h %b%b want %h %b%b", n, data_o, pe_o, fe_o, d, exp_perr(d, p, 1'b1), ~s);
      end
`ifdef UART_RX_OVERRUN_EN
      checks++;
      if (ovr_e !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ovr[%0d] got %b want %b", n, ovr_e, exp_rdy);
      end
`endif
      exp_rdy = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h81;
    checks++;
    if (rdy_e !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got rdy=%b want 1", rdy_e);
    end
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = d[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({data_e, rdy_e, pe_e, fe_e} !== 11'd0) begin
      errors++;
      $display("FAIL rstmid_async got %h %b%b%b want 00 000", data_e, rdy_e, pe_e, fe_e);
    end
`ifdef UART_RX_OVERRUN_EN
    checks++;
    if (ovr_e !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ovr got %b want 0", ovr_e);
    end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rx = 1'b1;
    repeat (20 * TICK_DIV) @(negedge clk);
    checks++;
    if (rdy_e !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_partial got rdy=%b want 0", rdy_e);
    end
    send_frame(8'h42, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({data_e, rdy_e, pe_e, fe_e} !== {8'h42, 1'b1, exp_perr(8'h42, 1'b0, 1'b0), 1'b0}) begin
      errors++;
      $display("FAIL rstmid_after got %h %b%b%b want 42 100", data_e, rdy_e, pe_e, fe_e);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    rd  = 1'b0;
    test_reset();
    test_clean();
    test_parity();
    test_frame();
    test_glitch();
    test_handshake();
`ifdef UART_RX_OVERRUN_EN
    test_overrun();
`endif
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
